// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset datapath: sequences fetch/decode/
// execute/memory/writeback, drives every datapath select, flags unsupported encodings.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_field,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALU_Control,
  output logic [1:0]       ImmSel,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             illegal,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXE_R   = 4'd2,
    EXE_I   = 4'd3,
    MEM_ADR = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WR  = 4'd6,
    WB_ALU  = 4'd7,
    WB_MEM  = 4'd8,
    BRANCH  = 4'd9,
    JAL     = 4'd10,
    LUI     = 4'd11,
    ILLEGAL = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic             w_fn_ok;
  logic [2:0]       w_fn_alu;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic             w_f7_zero;
  logic             w_unused;

  assign w_opcode  = inst_field[6:0];
  assign w_funct3  = inst_field[14:12];
  assign w_funct7  = inst_field[31:25];
  assign w_f7_zero = (w_funct7 == 7'b0000000);
  assign w_unused  = &{1'b0, inst_field[24:15], inst_field[11:7]};

  // funct7 only qualifies R-type ops, except SRLI where it is part of the encoding
  always_comb begin
    w_fn_alu = 3'b010;
    w_fn_ok  = 1'b0;
    case (w_funct3)
      3'b000: begin
        if (r_state != EXE_R || w_f7_zero) begin
          w_fn_ok = 1'b1;
        end else if (w_funct7 == 7'b0100000) begin
          w_fn_alu = 3'b110;
          w_fn_ok  = 1'b1;
        end
      end
      3'b111: begin w_fn_alu = 3'b000; w_fn_ok = (r_state != EXE_R) || w_f7_zero; end
      3'b110: begin w_fn_alu = 3'b001; w_fn_ok = (r_state != EXE_R) || w_f7_zero; end
      3'b100: begin w_fn_alu = 3'b100; w_fn_ok = (r_state != EXE_R) || w_f7_zero; end
      3'b010: begin w_fn_alu = 3'b111; w_fn_ok = (r_state != EXE_R) || w_f7_zero; end
      3'b101: begin w_fn_alu = 3'b101; w_fn_ok = w_f7_zero; end
      default: w_fn_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == ILLEGAL) r_illegal <= 1'b1;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      FETCH: if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (w_opcode)
          7'b0110011:            w_next = EXE_R;
          7'b0010011:            w_next = EXE_I;
          7'b0000011, 7'b0100011: w_next = MEM_ADR;
          7'b1100011:            w_next = BRANCH;
          7'b1101111:            w_next = JAL;
          7'b0110111:            w_next = LUI;
          default:               w_next = ILLEGAL;
        endcase
      end
      EXE_R, EXE_I: w_next = w_fn_ok ? WB_ALU : ILLEGAL;
      MEM_ADR:      w_next = w_opcode[5] ? MEM_WR : MEM_RD;
      MEM_RD:       if (mem_ready) w_next = WB_MEM;
      MEM_WR: begin
        if (mem_ready) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end
      end
      WB_ALU, WB_MEM, JAL, LUI: begin
        w_next   = FETCH;
        w_retire = 1'b1;
      end
      BRANCH: begin
        if (w_funct3 == 3'b000) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = ILLEGAL;
        end
      end
      ILLEGAL: w_next = ILLEGAL;
      default: w_next = ILLEGAL;
    endcase
  end

  // Write enables are suppressed in the reset cycle so an abandoned instruction has no side effects
  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_Control = 3'b000;
    ImmSel      = 2'b00;
    MemtoReg    = 2'b00;
    RegWrite    = 1'b0;
    case (r_state)
      FETCH: begin
        MemRead     = 1'b1;
        ALUSrcB     = 2'b01;
        ALU_Control = 3'b010;
        IRWrite     = mem_ready && !rst;
        PCWrite     = mem_ready && !rst;
      end
      DECODE: begin
        ALUSrcB     = 2'b10;
        ALU_Control = 3'b010;
        if (w_opcode == 7'b1100011)      ImmSel = 2'b10;
        else if (w_opcode == 7'b1101111) ImmSel = 2'b11;
        else                             ImmSel = 2'b00;
      end
      EXE_R: begin
        ALUSrcA     = 1'b1;
        ALU_Control = w_fn_alu;
      end
      EXE_I: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_Control = w_fn_alu;
      end
      MEM_ADR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_Control = 3'b010;
        ImmSel      = w_opcode[5] ? 2'b01 : 2'b00;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WR: begin
        MemWrite = !rst;
        IorD     = 1'b1;
      end
      WB_ALU: RegWrite = !rst;
      WB_MEM: begin
        RegWrite = !rst;
        MemtoReg = 2'b01;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Control = 3'b110;
        PCSrc       = 1'b1;
        PCWrite     = zero && (w_funct3 == 3'b000) && !rst;
      end
      JAL: begin
        RegWrite = !rst;
        MemtoReg = 2'b10;
        PCSrc    = 1'b1;
        PCWrite  = !rst;
        ImmSel   = 2'b11;
      end
      LUI: begin
        RegWrite = !rst;
        MemtoReg = 2'b11;
      end
      default: ;
    endcase
  end

  assign illegal   = r_illegal;
  assign state_out = r_state;
  assign instret   = r_instret;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: table of instruction vectors with expected state
// walks, per-cycle expectations queued as a scoreboard, plus reset/illegal/wrap sequences.
module tb_mc_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   inst_field = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA;
  logic [1:0]    ALUSrcB, ImmSel, MemtoReg;
  logic [2:0]    ALU_Control;
  logic          RegWrite, illegal;
  logic [3:0]    state_out;
  logic [CW-1:0] instret;

  mc_ctrl #(.CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .inst_field(inst_field), .zero(zero), .mem_ready(mem_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALU_Control(ALU_Control), .ImmSel(ImmSel), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .illegal(illegal), .state_out(state_out), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        zero;
    logic [2:0]  alu;   // ALU_Control expected in EXE_R/EXE_I
    logic [1:0]  isd;   // ImmSel in DECODE
    logic [1:0]  ism;   // ImmSel in MEM_ADR
    logic        ret;
    logic        dc;    // ALU_Control not checked in EXE states
    int unsigned n;
    logic [63:0] seq;   // state walk, first state in the most significant used nibble
  } vec_t;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic        dc;
    logic [CW-1:0] cnt;
  } exp_t;

  vec_t          tbl[17];
  vec_t          cur;
  vec_t          v_ill, v_sra;
  exp_t          sb[$];
  logic [CW-1:0] exp_cnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic vec_t mk(input string nm, input logic [31:0] ins, input logic z,
                              input logic [2:0] alu, input logic [1:0] isd, input logic [1:0] ism,
                              input logic ret, input logic dc, input int unsigned n,
                              input logic [63:0] seq);
    vec_t v;
    v.name = nm; v.inst = ins; v.zero = z; v.alu = alu; v.isd = isd; v.ism = ism;
    v.ret = ret; v.dc = dc; v.n = n; v.seq = seq;
    return v;
  endfunction

  // Packing: {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
  //           ALU_Control, ImmSel, MemtoReg, RegWrite, illegal}
  function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic mr, input logic r,
                                           input vec_t v);
    logic mrd, mwr, iord, irw, pcw, pcs, asa, rw, ill;
    logic [1:0] asb, isel, m2r;
    logic [2:0] alu;
    mrd = 0; mwr = 0; iord = 0; irw = 0; pcw = 0; pcs = 0; asa = 0; rw = 0; ill = 0;
    asb = 2'b00; isel = 2'b00; m2r = 2'b00; alu = 3'b000;
    case (s)
      4'd0:  begin mrd = 1; asb = 2'b01; alu = 3'b010; irw = mr; pcw = mr; end
      4'd1:  begin asb = 2'b10; alu = 3'b010; isel = v.isd; end
      4'd2:  begin asa = 1; alu = v.alu; end
      4'd3:  begin asa = 1; asb = 2'b10; alu = v.alu; end
      4'd4:  begin asa = 1; asb = 2'b10; alu = 3'b010; isel = v.ism; end
      4'd5:  begin mrd = 1; iord = 1; end
      4'd6:  begin mwr = 1; iord = 1; end
      4'd7:  rw = 1;
      4'd8:  begin rw = 1; m2r = 2'b01; end
      4'd9:  begin asa = 1; alu = 3'b110; pcs = 1; pcw = v.zero; end
      4'd10: begin rw = 1; m2r = 2'b10; pcs = 1; pcw = 1; isel = 2'b11; end
      4'd11: begin rw = 1; m2r = 2'b11; end
      4'd15: ill = 1;
      default: ;
    endcase
    if (r) begin rw = 0; mwr = 0; pcw = 0; irw = 0; end
    return {mrd, mwr, iord, irw, pcw, pcs, asa, asb, alu, isel, m2r, rw, ill};
  endfunction

  task automatic check_out();
    exp_t e;
    logic [17:0] act;
    e = sb.pop_front();
    act = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
           ALU_Control, ImmSel, MemtoReg, RegWrite, illegal};
    if (e.dc) act[8:6] = e.ctrl[8:6];
    n_tests++;
    if (state_out !== e.st || act !== e.ctrl || instret !== e.cnt) begin
      n_fail++;
      $display("FAIL %s st%0d: got state=%0d ctrl=%h instret=%0d, want state=%0d ctrl=%h instret=%0d",
               e.name, e.st, state_out, act, instret, e.st, e.ctrl, e.cnt);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic mr, input logic r);
    exp_t e;
    inst_field = cur.inst;
    zero       = cur.zero;
    mem_ready  = mr;
    rst        = r;
    e.name = cur.name;
    e.st   = s;
    e.ctrl = exp_ctrl(s, mr, r, cur);
    e.dc   = cur.dc && (s == 4'd2 || s == 4'd3);
    e.cnt  = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  // mem_ready is held low whenever the walk repeats a state, high otherwise
  task automatic run_vec(input vec_t v);
    logic [3:0] s, nx;
    logic       mr;
    cur = v;
    for (int unsigned k = 0; k < v.n; k++) begin
      s  = v.seq[4*(v.n-1-k) +: 4];
      mr = 1'b1;
      if (k + 1 < v.n) begin
        nx = v.seq[4*(v.n-2-k) +: 4];
        if (nx == s) mr = 1'b0;
      end
      step(s, mr, 1'b0);
    end
    if (v.ret) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    tbl[0]  = mk("add_stall", 32'h002081B3, 0, 3'b010, 2'b00, 2'b00, 1, 0, 7, 64'h0000127);
    tbl[1]  = mk("add",  32'h002081B3, 0, 3'b010, 2'b00, 2'b00, 1, 0, 4, 64'h0127);
    tbl[2]  = mk("sub",  32'h402081B3, 0, 3'b110, 2'b00, 2'b00, 1, 0, 4, 64'h0127);
    tbl[3]  = mk("and",  32'h0020F1B3, 0, 3'b000, 2'b00, 2'b00, 1, 0, 4, 64'h0127);
    tbl[4]  = mk("or",   32'h0020E1B3, 0, 3'b001, 2'b00, 2'b00, 1, 0, 4, 64'h0127);
    tbl[5]  = mk("xor",  32'h0020C1B3, 0, 3'b100, 2'b00, 2'b00, 1, 0, 4, 64'h0127);
    tbl[6]  = mk("slt",  32'h0020A1B3, 0, 3'b111, 2'b00, 2'b00, 1, 0, 4, 64'h0127);
    tbl[7]  = mk("srl",  32'h0020D1B3, 0, 3'b101, 2'b00, 2'b00, 1, 0, 4, 64'h0127);
    tbl[8]  = mk("addi", 32'h00508193, 0, 3'b010, 2'b00, 2'b00, 1, 0, 4, 64'h0137);
    tbl[9]  = mk("xori", 32'h0050C193, 0, 3'b100, 2'b00, 2'b00, 1, 0, 4, 64'h0137);
    tbl[10] = mk("srli", 32'h0050D193, 0, 3'b101, 2'b00, 2'b00, 1, 0, 4, 64'h0137);
    tbl[11] = mk("lw",   32'h0000A183, 0, 3'b010, 2'b00, 2'b00, 1, 0, 7, 64'h0145558);
    tbl[12] = mk("sw",   32'h0020A023, 0, 3'b010, 2'b00, 2'b01, 1, 0, 5, 64'h01466);
    tbl[13] = mk("beq_t", 32'h00000463, 1, 3'b010, 2'b10, 2'b00, 1, 0, 3, 64'h019);
    tbl[14] = mk("beq_f", 32'h00000463, 0, 3'b010, 2'b10, 2'b00, 1, 0, 3, 64'h019);
    tbl[15] = mk("jal",  32'h008000EF, 0, 3'b010, 2'b11, 2'b00, 1, 0, 3, 64'h01A);
    tbl[16] = mk("lui",  32'h000011B7, 0, 3'b010, 2'b00, 2'b00, 1, 0, 3, 64'h01B);
    v_ill   = mk("ill_op", 32'h0000007F, 0, 3'b010, 2'b00, 2'b00, 0, 0, 12, 64'h01FFFFFFFFFF);
    v_sra   = mk("ill_fn", 32'h4020D1B3, 0, 3'b010, 2'b00, 2'b00, 0, 1, 5, 64'h012FF);

    cur = tbl[0];
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) run_vec(tbl[i]);

    // Unsupported opcode: terminal ILLEGAL, counter frozen, cleared only by reset
    run_vec(v_ill);
    step(4'd15, 1'b0, 1'b1);
    exp_cnt = '0;
    step(4'd0, 1'b0, 1'b0);

    // Sixteen LUI retirements take the 4-bit counter through 15 and back to 0
    for (int i = 0; i < 16; i++) run_vec(tbl[16]);
    step(4'd0, 1'b0, 1'b0);

    // Reset while a store is waiting for memory: no write in the reset cycle or after
    cur = tbl[12];
    step(4'd0, 1'b1, 1'b0);
    step(4'd1, 1'b1, 1'b0);
    step(4'd4, 1'b1, 1'b0);
    step(4'd6, 1'b0, 1'b0);
    step(4'd6, 1'b1, 1'b1);
    exp_cnt = '0;
    step(4'd0, 1'b0, 1'b0);

    // Unsupported funct7 on an R-type shift never writes back
    run_vec(v_sra);
    step(4'd15, 1'b0, 1'b1);
    exp_cnt = '0;
    step(4'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
